// File: rtl/qsfp_seq_pkg.sv
// Shared types and helpers for the QSFP cage sequencer.
package qsfp_seq_pkg;

    localparam int STATE_W = 2;

    // Per-cage sequencing state; the encoding is visible on state_o for ILA use.
    typedef enum logic [STATE_W-1:0] {
        ST_ABSENT    = 2'd0,
        ST_RESET     = 2'd1,
        ST_INIT_WAIT = 2'd2,
        ST_READY     = 2'd3
    } cage_state_t;

    // Counter width large enough to hold the largest phase length itself.
    function automatic int calc_cnt_w(input int debounce, input int pulse, input int init_wait);
        int m;
        m = debounce;
        if (pulse > m)     m = pulse;
        if (init_wait > m) m = init_wait;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/qsfp_cage_fsm.sv
// One QSFP cage: input synchronisers, a shared phase counter and the
// ABSENT -> RESET -> INIT_WAIT -> READY sequencing FSM.
module qsfp_cage_fsm
    import qsfp_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 1024,
    parameter int RESET_PULSE_CYCLES = 2048,
    parameter int INIT_WAIT_CYCLES   = 262144
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               modprsl_i,
    input  logic               intl_i,
    input  logic               reset_req_i,
    output logic               qsfp_resetl_o,
    output logic               ready_o,
    output logic               intr_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W = calc_cnt_w(DEBOUNCE_CYCLES, RESET_PULSE_CYCLES, INIT_WAIT_CYCLES);

    // Debounce leaves ABSENT on the cycle after the counter has reached the
    // debounce length; the timed phases leave on their last counted cycle.
    localparam logic [CNT_W-1:0] DEB_LIM   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic        prs_s1_q, prs_s2_q;
    logic        int_s1_q, int_s2_q;
    logic        present_s;
    logic        int_act_s;

    cage_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             resetl_q;
    logic             ready_q;
    logic             intr_q;

    // Two-flop synchronisers; reset to "absent" and "no interrupt".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prs_s1_q <= 1'b1;
            prs_s2_q <= 1'b1;
            int_s1_q <= 1'b1;
            int_s2_q <= 1'b1;
        end else begin
            prs_s1_q <= modprsl_i;
            prs_s2_q <= prs_s1_q;
            int_s1_q <= intl_i;
            int_s2_q <= int_s1_q;
        end
    end

    assign present_s = ~prs_s2_q;
    assign int_act_s = ~int_s2_q;

    // Saturating increment so a counter can never wrap back into range.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Sequencing FSM with registered outputs; removal outranks every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ABSENT;
            cnt_q    <= '0;
            resetl_q <= 1'b0;
            ready_q  <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            intr_q <= 1'b0;
            if (!present_s) begin
                state_q  <= ST_ABSENT;
                cnt_q    <= '0;
                resetl_q <= 1'b0;
                ready_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ABSENT: begin
                        resetl_q <= 1'b0;
                        ready_q  <= 1'b0;
                        if (cnt_q == DEB_LIM) begin
                            state_q <= ST_RESET;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    ST_RESET: begin
                        // Requests are ignored so the pulse is never stretched.
                        if (cnt_q == RST_LAST) begin
                            state_q  <= ST_INIT_WAIT;
                            cnt_q    <= '0;
                            resetl_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    ST_INIT_WAIT: begin
                        if (reset_req_i) begin
                            state_q  <= ST_RESET;
                            cnt_q    <= '0;
                            resetl_q <= 1'b0;
                        end else if (cnt_q == INIT_LAST) begin
                            state_q <= ST_READY;
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            intr_q  <= int_act_s;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    ST_READY: begin
                        if (reset_req_i) begin
                            state_q  <= ST_RESET;
                            cnt_q    <= '0;
                            resetl_q <= 1'b0;
                            ready_q  <= 1'b0;
                        end else begin
                            intr_q <= int_act_s;
                        end
                    end
                    default: begin
                        state_q  <= ST_ABSENT;
                        cnt_q    <= '0;
                        resetl_q <= 1'b0;
                        ready_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign qsfp_resetl_o = resetl_q;
    assign ready_o       = ready_q;
    assign intr_o        = intr_q;
    assign state_o       = state_q;

endmodule

// File: rtl/qsfp_cage_sequencer.sv
// Per-cage QSFP module management for NUM_CAGES independent cages.
module qsfp_cage_sequencer
    import qsfp_seq_pkg::*;
#(
    parameter int NUM_CAGES          = 2,
    parameter int DEBOUNCE_CYCLES    = 1024,
    parameter int RESET_PULSE_CYCLES = 2048,
    parameter int INIT_WAIT_CYCLES   = 262144
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CAGES-1:0]         modprsl_i,
    input  logic [NUM_CAGES-1:0]         intl_i,
    input  logic [NUM_CAGES-1:0]         reset_req_i,
    output logic [NUM_CAGES-1:0]         qsfp_resetl_o,
    output logic [NUM_CAGES-1:0]         ready_o,
    output logic [NUM_CAGES-1:0]         intr_o,
    output logic [STATE_W*NUM_CAGES-1:0] state_o
);

    // One fully independent sequencer per cage; state fields packed cage 0 first.
    for (genvar i = 0; i < NUM_CAGES; i++) begin : g_cage
        qsfp_cage_fsm #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .RESET_PULSE_CYCLES(RESET_PULSE_CYCLES),
            .INIT_WAIT_CYCLES  (INIT_WAIT_CYCLES)
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .modprsl_i    (modprsl_i[i]),
            .intl_i       (intl_i[i]),
            .reset_req_i  (reset_req_i[i]),
            .qsfp_resetl_o(qsfp_resetl_o[i]),
            .ready_o      (ready_o[i]),
            .intr_o       (intr_o[i]),
            .state_o      (state_o[STATE_W*i +: STATE_W])
        );
    end

endmodule

// File: tb/tb_qsfp_cage_sequencer.sv
// Bench for qsfp_cage_sequencer: timeline model of each cage plus literal checks.
module tb_qsfp_cage_sequencer;

    localparam int NC  = 2;
    localparam int DEB = 4;
    localparam int RP  = 8;
    localparam int IW  = 16;

    logic            clk;
    logic            rst_n;
    logic [NC-1:0]   modprsl;
    logic [NC-1:0]   intl;
    logic [NC-1:0]   reset_req;
    logic [NC-1:0]   resetl;
    logic [NC-1:0]   ready;
    logic [NC-1:0]   intr;
    logic [2*NC-1:0] state;

    int total = 0;
    int bad   = 0;

    qsfp_cage_sequencer #(
        .NUM_CAGES         (NC),
        .DEBOUNCE_CYCLES   (DEB),
        .RESET_PULSE_CYCLES(RP),
        .INIT_WAIT_CYCLES  (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .modprsl_i    (modprsl),
        .intl_i       (intl),
        .reset_req_i  (reset_req),
        .qsfp_resetl_o(resetl),
        .ready_o      (ready),
        .intr_o       (intr),
        .state_o      (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model: a cage is a timeline. seq_start is the edge on which the reset
    // pulse began (-1 = absent); the phase follows from the elapsed edges.
    int          cyc = 0;
    int          seq_start[NC];
    int          run[NC];
    logic [NC-1:0] mp_d1, mp_d2, il_d1, il_d2;
    logic [NC-1:0] intr_m;

    function automatic int model_state(input int c);
        int el;
        if (seq_start[c] < 0) return 0;
        el = cyc - seq_start[c];
        if (el < RP)      return 1;
        if (el < RP + IW) return 2;
        return 3;
    endfunction

    task automatic model_step();
        bit pres;
        int prev_el;
        cyc = cyc + 1;
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                seq_start[c] = -1;
                run[c]       = 0;
            end
            mp_d1 = '1; mp_d2 = '1; il_d1 = '1; il_d2 = '1;
            intr_m = '0;
            return;
        end
        for (int c = 0; c < NC; c++) begin
            pres    = ~mp_d2[c];
            prev_el = (cyc - 1) - seq_start[c];
            if (seq_start[c] < 0) begin
                if (pres) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DEB + 1) begin
                        seq_start[c] = cyc;
                        run[c]       = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end else if (!pres) begin
                seq_start[c] = -1;
                run[c]       = 0;
            end else if (reset_req[c] && prev_el >= RP) begin
                seq_start[c] = cyc;
            end
            intr_m[c] = (model_state(c) == 3) && !il_d2[c];
        end
        mp_d2 = mp_d1; mp_d1 = modprsl;
        il_d2 = il_d1; il_d1 = intl;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Scoreboard: every cycle out of reset, all outputs against the model.
    initial begin
        logic [4*NC+2*NC-1:0] exp_v, act_v;
        logic [2*NC-1:0] e_st;
        logic [NC-1:0]   e_res, e_rdy;
        int st;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int c = 0; c < NC; c++) begin
                    st = model_state(c);
                    e_st[2*c +: 2] = 2'(st);
                    e_res[c] = (st >= 2);
                    e_rdy[c] = (st == 3);
                end
                exp_v = {e_st, e_res, e_rdy, intr_m};
                act_v = {state, resetl, ready, intr};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL model cyc=%0d: state/resetl/ready/intr got %b expected %b",
                             cyc, act_v, exp_v);
                end
            end
        end
    end

    // Literal checks pinning the model to the hand-computed timeline.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    int t, t2, r, g, f, t1, e;

    initial begin
        rst_n = 1'b0; modprsl = '1; intl = '1; reset_req = '0;
        #1;
        check("async_rst_resetl", 32'(resetl), 0);
        check("async_rst_ready",  32'(ready), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Empty cages stay idle.
        repeat (20) @(negedge clk);
        check("idle_state",  32'(state), 0);
        check("idle_resetl", 32'(resetl), 0);
        check("idle_ready",  32'(ready), 0);

        // Cage 0 insertion.
        modprsl[0] = 1'b0; t = cyc + 1;
        at_cycle(t + 13); check("ins_resetl_low",  32'(resetl[0]), 0);
        at_cycle(t + 14); check("ins_resetl_high", 32'(resetl[0]), 1);
        at_cycle(t + 29); check("ins_ready_low",   32'(ready[0]), 0);
        at_cycle(t + 30); check("ins_ready_high",  32'(ready[0]), 1);
        check("ins_cage1_state", 32'(state[3:2]), 0);
        check("ins_cage1_resetl", 32'(resetl[1]), 0);

        // Interrupt in READY.
        at_cycle(t + 33); intl[0] = 1'b0; t2 = cyc + 1;
        at_cycle(t2 + 1); check("intr_early", 32'(intr[0]), 0);
        at_cycle(t2 + 2); check("intr_ready", 32'(intr[0]), 1);
        at_cycle(t2 + 4); intl[0] = 1'b1;

        // Software reset with a second request during RESET.
        at_cycle(t2 + 8); reset_req[0] = 1'b1; r = cyc + 1;
        at_cycle(r); reset_req[0] = 1'b0;
        check("req_state", 32'(state[1:0]), 1);
        check("req_ready", 32'(ready[0]), 0);
        at_cycle(r + 2); reset_req[0] = 1'b1;
        at_cycle(r + 3); reset_req[0] = 1'b0;
        at_cycle(r + 7); check("req_resetl_low",  32'(resetl[0]), 0);
        at_cycle(r + 8); check("req_resetl_high", 32'(resetl[0]), 1);
        at_cycle(r + 10); intl[0] = 1'b0;
        at_cycle(r + 14); check("intr_init_wait", 32'(intr[0]), 0);
        check("init_wait_state", 32'(state[1:0]), 2);
        at_cycle(r + 23); check("req_ready_low",  32'(ready[0]), 0);
        at_cycle(r + 24); check("req_ready_high", 32'(ready[0]), 1);
        check("intr_on_ready", 32'(intr[0]), 1);
        at_cycle(r + 26); intl[0] = 1'b1;

        // Removal beats a simultaneous reset request.
        at_cycle(r + 30); modprsl[0] = 1'b1; g = cyc + 1;
        at_cycle(g + 1); reset_req[0] = 1'b1;
        at_cycle(g + 2); reset_req[0] = 1'b0;
        check("rm_state",  32'(state[1:0]), 0);
        check("rm_resetl", 32'(resetl[0]), 0);

        // Bouncing insertion: low 3, high 1, then low.
        at_cycle(g + 6);  modprsl[0] = 1'b0;
        at_cycle(g + 9);  modprsl[0] = 1'b1;
        at_cycle(g + 10); modprsl[0] = 1'b0; f = cyc + 1;
        at_cycle(f + 13); check("bounce_resetl_low", 32'(resetl[0]), 0);
        at_cycle(f + 29); check("bounce_ready_low",  32'(ready[0]), 0);
        at_cycle(f + 30); check("bounce_ready_high", 32'(ready[0]), 1);

        // Cage 1 removed in INIT_WAIT together with a reset request.
        at_cycle(f + 32); modprsl[1] = 1'b0; t1 = cyc + 1;
        at_cycle(t1 + 20);
        check("c1_init_wait", 32'(state[3:2]), 2);
        modprsl[1] = 1'b1; reset_req[1] = 1'b1; e = cyc + 1;
        at_cycle(e); reset_req[1] = 1'b0;
        check("c1_req_state", 32'(state[3:2]), 1);
        at_cycle(e + 1); intl[0] = 1'b0;
        check("c1_still_reset", 32'(state[3:2]), 1);
        at_cycle(e + 2);
        check("c1_absent",  32'(state[3:2]), 0);
        check("c1_resetl",  32'(resetl[1]), 0);

        // Asynchronous reset in READY.
        at_cycle(e + 4);
        check("pre_rst_ready", 32'(ready[0]), 1);
        check("pre_rst_intr",  32'(intr[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_resetl", 32'(resetl), 0);
        check("mid_rst_ready",  32'(ready), 0);
        check("mid_rst_intr",   32'(intr), 0);
        check("mid_rst_state",  32'(state), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; intl[0] = 1'b1;
        t = cyc + 1;
        at_cycle(t + 10);
        check("post_rst_state", 32'(state[1:0]), 1);
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsfp_cage_sequencer.md
Name: qsfp_cage_sequencer

Overview:
- Parametrised, per-cage QSFP module management for N cages; replaces static tie-high of QSFP ResetL in GT test tops.
- Per cage: synchronises and debounces ModPrsL, enforces a minimum ResetL pulse and a post-reset init wait, then reports ready.
- Sits beside the GT/IBERT core in each board top.
- Qualifies IntL and supports software-requested resets per cage.

Parameters:
- NUM_CAGES, 2, number of QSFP cages handled (1..16).
- DEBOUNCE_CYCLES, 1024, consecutive cycles of stable "present" required before sequencing (>=1).
- RESET_PULSE_CYCLES, 2048, cycles ResetL held low in RESET (>=1).
- INIT_WAIT_CYCLES, 262144, cycles after ResetL release before ready (>=1).
- CNT_W, derived, $clog2 of max(DEBOUNCE, RESET_PULSE, INIT_WAIT)+1; not overridden.

Ports:
- clk, input, 1: system clock; all logic in this domain.
- rst_n, input, 1: asynchronous active-low reset.
- modprsl_i, input, NUM_CAGES: QSFP ModPrsL; async, low = module present.
- intl_i, input, NUM_CAGES: QSFP IntL; async, low = interrupt.
- reset_req_i, input, NUM_CAGES: single-cycle request to re-reset the cage.
- qsfp_resetl_o, output, NUM_CAGES: QSFP ResetL; low = module held in reset.
- ready_o, output, NUM_CAGES: module present and initialised.
- intr_o, output, NUM_CAGES: synchronised interrupt, gated by ready_o.
- state_o, output, 2*NUM_CAGES: per-cage state encoding, for debug/ILA.

Behaviour:
- Reset values while rst_n low: qsfp_resetl_o = all 0, ready_o = 0, intr_o = 0, every state = ABSENT, counters = 0. Assertion is async; deassertion is sampled on clk.
- Synchronisers: modprsl_i and intl_i pass through 2-FF synchronisers reset to 1 (absent / no interrupt). Define present_s = ~sync(modprsl_i).
- All outputs are registered. Cages are fully independent.
- State encodings: ABSENT=0, RESET=1, INIT_WAIT=2, READY=3.
- ABSENT: resetl=0, ready=0.
  - Counter increments while present_s = 1; clears to 0 on any cycle present_s = 0.
  - On the cycle the counter reaches DEBOUNCE_CYCLES: go to RESET, clear counter.
- RESET: resetl=0.
  - Counter counts RESET_PULSE_CYCLES, then go to INIT_WAIT, clear counter.
  - reset_req_i is ignored here; the pulse is not extended.
- INIT_WAIT: resetl=1, ready=0.
  - After INIT_WAIT_CYCLES, go to READY.
  - reset_req_i = 1: go to RESET, clear counter.
- READY: resetl=1, ready=1, intr = ~sync(intl_i).
  - reset_req_i = 1: go to RESET; ready drops the next cycle.
- Removal: present_s = 0 in RESET, INIT_WAIT or READY forces ABSENT next cycle (resetl=0, ready=0, counter cleared). Removal has priority over reset_req_i and over counter expiry in the same cycle.
- Latency: modprsl_i falls before edge t with no bounce → RESET entered at t+2+DEBOUNCE, resetl rises at t+2+DEBOUNCE+RESET_PULSE, ready_o rises at t+2+DEBOUNCE+RESET_PULSE+INIT_WAIT.
- Counters saturate and never wrap. The counter is shared per cage and cleared on every state change.
- intr_o is 0 in every state other than READY.

Decomposition:
- Package qsfp_seq_pkg:
  - cage_state_t enum (2-bit, encodings above).
  - Constants for state widths.
  - Function to compute CNT_W.
- Sub-module qsfp_cage_fsm: one cage.
  - Contains the synchronisers, counter and FSM.
  - Takes DEBOUNCE/RESET_PULSE/INIT_WAIT as parameters.
- Top instantiates NUM_CAGES copies in a generate loop and concatenates outputs.

Test Plan (NUM_CAGES=2, DEBOUNCE=4, RESET_PULSE=8, INIT_WAIT=16):
- Power-up with modprsl_i=2'b11, rst_n released → qsfp_resetl_o=2'b00, ready_o=0, state_o=0 held indefinitely.
- Cage0 modprsl_i drops before edge t, stays low:
  - resetl_o[0]=0 until t+14, rises at t+14.
  - ready_o[0] rises at t+30.
  - Cage1 unaffected.
- Cage0 modprsl_i bounces (low 3 cycles, high 1, then low) → debounce restarts; ready_o[0] rises 30 cycles after the final falling edge.
- Cage0 READY, reset_req_i[0] pulsed → next cycle state=RESET, ready_o[0]=0, resetl_o[0]=0 for 8 cycles, ready returns 24 cycles after the request. A second pulse during RESET does not lengthen the low time.
- Cage0 READY, intl_i[0] low → intr_o[0]=1 two cycles later. Same stimulus in INIT_WAIT → intr_o[0]=0.
- Cage1 in INIT_WAIT, modprsl_i[1] rises in the same cycle reset_req_i[1]=1 → ABSENT two cycles after the input edge, resetl_o[1]=0. Async rst_n pulse mid-READY → all outputs zero immediately.
